shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 96 +++++++++
 tb/tb_shift_add_multiplier.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - unsigned sequential shift-and-add multiplier
// One add/shift step per CALC cycle; 2N-bit product after N steps.
module shift_add_multiplier #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           ready,
  output logic           done
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   q_q, q_d;
  logic           c_q, c_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;
  logic           done_q, done_d;

  logic [N:0]     sum;
  logic [2*N:0]   shifted;

  // N+1-bit add keeps the carry, which the shift moves into A's MSB.
  assign sum     = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
  assign shifted = {sum, q_q} >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      c_q       <= c_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    c_d       = c_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          c_d     = 1'b0;
          count_d = CW'(N);
          state_d = CALC;
        end
      end
      CALC: begin
        c_d     = shifted[2*N];
        a_d     = shifted[2*N-1:N];
        q_d     = shifted[N-1:0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = shifted[2*N-1:0];
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign done    = done_q;
  assign ready   = (state_q == IDLE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed self-checking bench for shift_add_multiplier
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_shift_add_multiplier;
  localparam int N  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   multiplicand = '0;
  logic [N-1:0]   multiplier = '0;
  logic [2*N-1:0] product;
  logic           ready;
  logic           done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  shift_add_multiplier #(.N(N), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after acceptance until ready returns, bounded.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_mul(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                         input logic [2*N-1:0] expected);
    int cyc;
    wait_ready(cyc);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    check({tag, " busy"}, 32'(ready), 32'd0);
    wait_ready(cyc);
    check({tag, " cycles"}, 32'(cyc), 32'(N));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " product"}, 32'(product), 32'(expected));
    tick();
    check({tag, " done clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  bad;
    bit  saw_done;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset ready", 32'(ready), 32'd1);
    check("reset product", 32'(product), 32'd0);
    check("reset done", 32'(done), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready !== 1'b1 || product !== '0 || done !== 1'b0) bad = 1'b1;
    end
    check("idle stable", 32'(bad), 32'd0);

    run_mul("13x11", 8'd13, 8'd11, 16'h008F);
    run_mul("255x255", 8'd255, 8'd255, 16'hFE01);
    run_mul("128x2", 8'd128, 8'd2, 16'h0100);
    run_mul("0x200", 8'd0, 8'd200, 16'd0);
    run_mul("200x1", 8'd200, 8'd1, 16'd200);
    run_mul("1x0", 8'd1, 8'd0, 16'd0);

    // Busy: second start at E+3 is ignored, then start held high.
    multiplicand = 8'd5;
    multiplier   = 8'd6;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("busy ignore ready", 32'(ready), 32'd0);
    cyc = 3;
    while (!ready && cyc < 40) begin
      tick();
      cyc++;
    end
    check("busy cycles", 32'(cyc), 32'(N));
    check("busy product", 32'(product), 32'd30);
    multiplicand = 8'd7;
    multiplier   = 8'd7;
    start        = 1'b1;
    tick();
    check("held accept E+9", 32'(ready), 32'd0);
    for (int i = 0; i < N; i++) tick();
    check("held ready E+17", 32'(ready), 32'd1);
    check("held done E+17", 32'(done), 32'd1);
    check("held product", 32'(product), 32'd49);
    tick();
    check("held reaccept", 32'(ready), 32'd0);
    check("held done clear", 32'(done), 32'd0);
    start = 1'b0;
    wait_ready(cyc);
    check("held second product", 32'(product), 32'd49);

    // Asynchronous reset between E+4 and E+5.
    multiplicand = 8'd100;
    multiplier   = 8'd3;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort product", 32'(product), 32'd0);
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort no done", 32'(saw_done), 32'd0);
    check("abort product held", 32'(product), 32'd0);
    run_mul("2x3", 8'd2, 8'd3, 16'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
